// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: operand width, funct3 opcodes and the unit's FSM state encoding.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    // funct3 encodings of the RV32M instructions
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // most negative signed value, the dividend of the signed overflow case
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
//   rem/quo/divisor   : current partial remainder, dividend/quotient shift register, divisor
//   rem_next_c/quo_next_c : combinational results after this step
module div_step
    import rv32m_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_next_c,
    output logic [XLEN-1:0] quo_next_c
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    always_comb begin
        shifted    = {rem[XLEN-1:0], quo[XLEN-1]};
        diff       = shifted - {1'b0, divisor};
        // a set top remainder bit means the true shifted value exceeds any divisor
        fits       = rem[XLEN] || (shifted >= {1'b0, divisor});
        rem_next_c = fits ? diff : shifted;
        quo_next_c = {quo[XLEN-2:0], fits};
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
//   clk, SYS_reset_n            : clock, async active-low reset
//   MD_start/funct3/rd/rs*_data : request, sampled only in IDLE
//   MD_kill                     : flush of the in-flight op
//   MD_busy, MD_done            : status, done is a one-cycle pulse
//   REG_write_*                 : register-file write port (x0 never written)
module mul_div_unit
    import rv32m_pkg::*;
#(
    parameter int unsigned DIV_STEPS = 1
) (
    input  logic            clk,
    input  logic            SYS_reset_n,
    input  logic            MD_start,
    input  logic [2:0]      MD_funct3,
    input  logic [4:0]      MD_rd,
    input  logic [XLEN-1:0] MD_rs1_data,
    input  logic [XLEN-1:0] MD_rs2_data,
    input  logic            MD_kill,
    output logic            MD_busy,
    output logic            MD_done,
    output logic [4:0]      REG_write_address,
    output logic            REG_write_enable,
    output logic [XLEN-1:0] REG_write_value
);

    localparam int unsigned DIV_ITERS = XLEN / DIV_STEPS;
    localparam int unsigned CNT_W     = $clog2(DIV_ITERS);
    localparam int unsigned PROD_W    = 2 * XLEN + 2;

    md_state_e       state_q, state_d;

    logic [2:0]      funct3_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] op_a_q, op_b_q;
    logic [XLEN:0]   rem_q;
    logic [XLEN-1:0] quo_q, dvsr_q;
    logic            neg_quo_q, neg_rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] result_q;
    logic            busy_q, done_q, we_q;

    // accept decode and special-case detection on the request ports
    logic            accept_c;
    logic            sdiv_c, a_neg_c, b_neg_c;
    logic            div_zero_c, div_ovf_c, special_c;
    logic [XLEN-1:0] special_val_c;
    logic [4:0]      rd_d_c;

    always_comb begin
        accept_c   = (state_q == IDLE) && MD_start && !MD_kill;
        sdiv_c     = !MD_funct3[0];
        a_neg_c    = sdiv_c && MD_rs1_data[XLEN-1];
        b_neg_c    = sdiv_c && MD_rs2_data[XLEN-1];
        div_zero_c = (MD_rs2_data == '0);
        div_ovf_c  = sdiv_c && (MD_rs1_data == INT_MIN) && (MD_rs2_data == '1);
        special_c  = MD_funct3[2] && (div_zero_c || div_ovf_c);
        if (div_zero_c) begin
            special_val_c = MD_funct3[1] ? MD_rs1_data : '1;
        end else begin
            special_val_c = MD_funct3[1] ? '0 : INT_MIN;
        end
        rd_d_c = accept_c ? MD_rd : rd_q;
    end

    // 33x33 product; operand sign extension selected by the high-half variant
    logic              a_signed_c, b_signed_c;
    logic [XLEN:0]     mul_a_c, mul_b_c;
    logic [PROD_W-1:0] prod_c;
    logic [XLEN-1:0]   mul_res_c;
    logic              unused_prod_hi;

    always_comb begin
        a_signed_c = (funct3_q != MD_MULHU);
        b_signed_c = (funct3_q == MD_MUL) || (funct3_q == MD_MULH);
        mul_a_c    = {a_signed_c && op_a_q[XLEN-1], op_a_q};
        mul_b_c    = {b_signed_c && op_b_q[XLEN-1], op_b_q};
        prod_c     = {{(XLEN+1){mul_a_c[XLEN]}}, mul_a_c} * {{(XLEN+1){mul_b_c[XLEN]}}, mul_b_c};
        mul_res_c  = (funct3_q == MD_MUL) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
    end

    assign unused_prod_hi = ^prod_c[PROD_W-1:2*XLEN];

    // DIV_STEPS restoring steps per cycle
    logic [XLEN:0]   rem_chain [DIV_STEPS+1];
    logic [XLEN-1:0] quo_chain [DIV_STEPS+1];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    for (genvar i = 0; i < DIV_STEPS; i++) begin : g_div_chain
        div_step u_div_step (
            .rem        (rem_chain[i]),
            .quo        (quo_chain[i]),
            .divisor    (dvsr_q),
            .rem_next_c (rem_chain[i+1]),
            .quo_next_c (quo_chain[i+1])
        );
    end

    // sign fix of the final quotient/remainder from the magnitudes
    logic [XLEN-1:0] quo_fin_c, rem_fin_c, div_res_c;

    always_comb begin
        quo_fin_c = quo_chain[DIV_STEPS];
        rem_fin_c = rem_chain[DIV_STEPS][XLEN-1:0];
        if (funct3_q[1]) begin
            div_res_c = neg_rem_q ? (XLEN'(0) - rem_fin_c) : rem_fin_c;
        end else begin
            div_res_c = neg_quo_q ? (XLEN'(0) - quo_fin_c) : quo_fin_c;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; kill overrides everything outside IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!MD_funct3[2]) begin
                        state_d = MUL;
                    end else if (special_c) begin
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            MUL:  state_d = DONE;
            DIV:  if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (MD_kill && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // operand latching, divide iteration and write-back registers
    always_ff @(posedge clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            funct3_q  <= '0;
            rd_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            if (accept_c) begin
                funct3_q  <= MD_funct3;
                rd_q      <= MD_rd;
                op_a_q    <= MD_rs1_data;
                op_b_q    <= MD_rs2_data;
                rem_q     <= '0;
                quo_q     <= a_neg_c ? (XLEN'(0) - MD_rs1_data) : MD_rs1_data;
                dvsr_q    <= b_neg_c ? (XLEN'(0) - MD_rs2_data) : MD_rs2_data;
                neg_quo_q <= a_neg_c ^ b_neg_c;
                neg_rem_q <= a_neg_c;
                cnt_q     <= CNT_W'(DIV_ITERS - 1);
            end else if (state_q == DIV) begin
                rem_q <= rem_chain[DIV_STEPS];
                quo_q <= quo_chain[DIV_STEPS];
                cnt_q <= cnt_q - CNT_W'(1);
            end

            // result is captured on entry to DONE and held afterwards
            if (state_d == DONE) begin
                if (state_q == MUL) begin
                    result_q <= mul_res_c;
                end else if (state_q == DIV) begin
                    result_q <= div_res_c;
                end else begin
                    result_q <= special_val_c;
                end
            end

            busy_q <= (state_d != IDLE);
            done_q <= (state_d == DONE);
            we_q   <= (state_d == DONE) && (rd_d_c != 5'd0);
        end
    end

    // kill in DONE must suppress the pulse in the same cycle
    assign MD_busy           = busy_q;
    assign MD_done           = done_q && !MD_kill;
    assign REG_write_enable  = we_q && !MD_kill;
    assign REG_write_address = rd_q;
    assign REG_write_value   = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized ops
// against an arithmetic reference model, and kill/reset/handshake sequences.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [4:0]  rd = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        kill = 1'b0;
    logic        busy, done, we;
    logic [4:0]  waddr;
    logic [31:0] wval;

    int passed = 0;
    int total  = 0;

    mul_div_unit dut (
        .clk               (clk),
        .SYS_reset_n       (rst_n),
        .MD_start          (start),
        .MD_funct3         (funct3),
        .MD_rd             (rd),
        .MD_rs1_data       (a),
        .MD_rs2_data       (b),
        .MD_kill           (kill),
        .MD_busy           (busy),
        .MD_done           (done),
        .REG_write_address (waddr),
        .REG_write_enable  (we),
        .REG_write_value   (wval)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] MIN = 32'h8000_0000;

    typedef struct {
        logic [2:0]  f;
        logic [4:0]  r;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] val;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // reference results straight from the RV32M arithmetic definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        int          ix, iy;
        longint      sx, sy, p;
        longint unsigned ux, uy, up;
        logic [31:0] res;
        ix = x; iy = y;
        sx = ix; sy = iy;
        ux = {32'd0, x}; uy = {32'd0, y};
        res = '0;
        case (f)
            3'd0: begin p = sx * sy; res = p[31:0]; end
            3'd1: begin p = sx * sy; res = p[63:32]; end
            3'd2: begin p = sx * longint'(uy); res = p[63:32]; end
            3'd3: begin up = ux * uy; res = up[63:32]; end
            3'd4: res = (y == 0) ? 32'hFFFF_FFFF : (x == MIN && y == 32'hFFFF_FFFF) ? MIN : 32'(ix / iy);
            3'd5: res = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: res = (y == 0) ? x : (x == MIN && y == 32'hFFFF_FFFF) ? 32'd0 : 32'(ix % iy);
            default: res = (y == 0) ? x : x % y;
        endcase
        return res;
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2]) return 2;
        if (y == 0 || (!f[0] && x == MIN && y == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // raise start at a falling edge and hold it until busy is seen
    task automatic issue(input logic [2:0] f, input logic [4:0] r, input logic [31:0] x,
                         input logic [31:0] y, output bit ok, output int waited);
        funct3 = f; rd = r; a = x; b = y; start = 1'b1;
        ok = 0; waited = 0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            waited++;
            if (busy) ok = 1;
        end
        start = 1'b0;
        if (!ok) check("accept_timeout", 32'(busy), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [4:0] r, input logic [31:0] x,
                          input logic [31:0] y, output logic [31:0] val, output int lat,
                          output logic wev, output logic [4:0] addr, output bit ok, output int waited);
        val = '0; lat = 0; wev = 1'b0; addr = '0;
        issue(f, r, x, y, ok, waited);
        if (!ok) return;
        ok = 0;
        for (int c = 1; c <= 60; c++) begin
            if (done) begin
                ok = 1; lat = c; val = wval; wev = we; addr = waddr;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic apply(input string name, input logic [2:0] f, input logic [4:0] r,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] exp_val, input int exp_lat);
        logic [31:0] val;
        int          lat, waited;
        logic        wev;
        logic [4:0]  addr;
        bit          ok;
        run_op(f, r, x, y, val, lat, wev, addr, ok, waited);
        if (ok) begin
            check($sformatf("%s value", name), val, exp_val);
            check($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
            check($sformatf("%s write_enable", name), 32'(wev), 32'(r != 5'd0));
            check($sformatf("%s write_address", name), 32'(addr), 32'(r));
            @(negedge clk);
            check($sformatf("%s done_one_cycle", name), 32'(done), 32'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MIN;
            4: return 32'($urandom_range(0, 50));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] val, x, y;
        logic [2:0]  f;
        logic [4:0]  r, addr;
        logic        wev;
        int          lat, waited, dones;
        bit          ok;

        vecs[0]  = '{3'd0, 5'd5,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[1]  = '{3'd3, 5'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[2]  = '{3'd1, 5'd7,  MIN,          MIN,           32'h4000_0000, 2};
        vecs[3]  = '{3'd2, 5'd8,  32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 2};
        vecs[4]  = '{3'd4, 5'd9,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 5'd10, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 5'd11, 32'd100,      32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 5'd12, 32'd100,      32'd7,         32'd2,         33};
        vecs[8]  = '{3'd4, 5'd13, 32'd1234,     32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 5'd14, 32'd9,        32'd0,         32'd9,         1};
        vecs[10] = '{3'd4, 5'd15, MIN,          32'hFFFF_FFFF, MIN,           1};
        vecs[11] = '{3'd6, 5'd16, MIN,          32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd0, 5'd0,  32'd3,        32'd3,         32'd9,         2};
        vecs[13] = '{3'd5, 5'd17, 32'd55,       32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{3'd6, 5'd18, 32'd5,        32'd0,         32'd5,         1};
        vecs[15] = '{3'd5, 5'd19, MIN,          32'hFFFF_FFFF, 32'd0,         33};
        vecs[16] = '{3'd7, 5'd20, MIN,          32'hFFFF_FFFF, MIN,           33};
        vecs[17] = '{3'd4, 5'd21, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};

        // reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset write_enable", 32'(we), 32'd0);
        check("reset write_address", 32'(waddr), 32'd0);
        check("reset write_value", wval, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors
        for (int i = 0; i < 18; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].f, vecs[i].r, vecs[i].x, vecs[i].y,
                  vecs[i].val, vecs[i].lat);
        end

        // randomized ops against the reference model
        for (int i = 0; i < 48; i++) begin
            f = 3'($urandom_range(0, 7));
            r = 5'($urandom_range(0, 31));
            x = pick();
            y = pick();
            apply($sformatf("rnd%0d f%0d %h %h", i, f, x, y), f, r, x, y, model(f, x, y), model_lat(f, x, y));
        end

        // back-to-back: start raised in the DONE cycle is accepted after one idle cycle
        run_op(3'd0, 5'd3, 32'd6, 32'd7, val, lat, wev, addr, ok, waited);
        run_op(3'd4, 5'd3, 32'd1, 32'd0, val, lat, wev, addr, ok, waited);
        check("b2b accept_wait", 32'(waited), 32'd2);
        check("b2b value", val, 32'hFFFF_FFFF);
        @(negedge clk);

        // kill together with start in IDLE is not accepted
        start = 1'b1; kill = 1'b1; funct3 = 3'd0; rd = 5'd4;
        repeat (3) @(negedge clk);
        check("kill_start busy", 32'(busy), 32'd0);
        start = 1'b0; kill = 1'b0;
        @(negedge clk);

        // start pulses while busy are ignored
        issue(3'd5, 5'd3, 32'd100, 32'd7, ok, waited);
        dones = 0;
        val = '0;
        for (int c = 2; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin dones++; val = wval; end
            funct3 = 3'd0; a = 32'd5; b = 32'd5;
            start = (c <= 30) ? c[0] : 1'b0;
        end
        start = 1'b0;
        check("pulses single_done", 32'(dones), 32'd1);
        check("pulses value", val, 32'd14);
        check("pulses idle", 32'(busy), 32'd0);

        // kill at DIV cycle 10
        issue(3'd4, 5'd9, 32'hFFFF_FFF9, 32'd2, ok, waited);
        for (int c = 2; c <= 10; c++) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill_div busy", 32'(busy), 32'd0);
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (done || we) dones++;
            @(negedge clk);
        end
        check("kill_div no_done", 32'(dones), 32'd0);
        check("kill_div value_held", wval, 32'd14);

        // kill during DONE gates done and write_enable in that cycle
        issue(3'd0, 5'd4, 32'd6, 32'd7, ok, waited);
        @(posedge clk);
        #1;
        check("kill_done pre_done", 32'(done), 32'd1);
        kill = 1'b1;
        #1;
        check("kill_done done", 32'(done), 32'd0);
        check("kill_done write_enable", 32'(we), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        @(negedge clk);
        check("kill_done busy", 32'(busy), 32'd0);

        // async reset mid-DIV clears outputs immediately
        issue(3'd5, 5'd7, 32'd1000, 32'd3, ok, waited);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid write_address", 32'(waddr), 32'd0);
        check("rst_mid write_value", wval, 32'd0);
        check("rst_mid write_enable", 32'(we), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply("after_reset", 3'd5, 5'd2, 32'd100, 32'd7, 32'd14, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected completion", total);
        $fatal(1);
    end

endmodule
